floor_request_tracker: RTL and testbench

//  Producer side of the direction-scoring interface: latches hall-call and car-call

---
 rtl/floor_request_tracker_pkg.sv | 33 +++
 rtl/floor_request_tracker_service_unit.sv | 135 +++++++++++++
 rtl/floor_request_tracker.sv | 78 +++++++
 tb/tb_floor_request_tracker.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/floor_request_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elevator_pkg
// Purpose  : Shared types and position-decode helper for the floor request
//            tracker and its per-car service units.
// Revision : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    typedef enum logic [1:0] {
        START  = 2'd0,
        SIM    = 2'd1,
        PAUSE  = 2'd2,
        ENDING = 2'd3
    } sim_state_e;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } svc_state_e;

    localparam int c_HALF_POS_W = 4;

    // Even half-positions are floor stops; anything above the top floor is invalid.
    function automatic logic half_pos_at_floor(
        input logic [c_HALF_POS_W-1:0] half_pos,
        input logic [c_HALF_POS_W-1:0] max_half_pos
    );
        return (half_pos[0] == 1'b0) && (half_pos <= max_half_pos);
    endfunction

endpackage
`default_nettype wire

// File: rtl/floor_request_tracker_service_unit.sv
`default_nettype none
// ============================================================================
// Module   : floor_service_unit
// Purpose  : One car's request/destination bitmaps, stop FSM and door-dwell
//            timer; emits a one-cycle serve pulse on each stop.
// Revision : 1.0 - initial release
// ============================================================================
module floor_service_unit
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = 6,
    parameter int DWELL_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  sim_state_e              i_sim_state,
    input  logic [NUM_FLOORS-1:0]   i_hall_pulse,
    input  logic [NUM_FLOORS-1:0]   i_car_pulse,
    input  logic [c_HALF_POS_W-1:0] i_half_pos,
    input  logic                    i_dir_up,
    output logic [NUM_FLOORS-1:0]   o_floors_requested,
    output logic [NUM_FLOORS-1:0]   o_floor_destinations,
    output logic                    o_door_open,
    output logic                    o_arrival_dir,
    output logic                    o_serve
);

    localparam int c_CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(DWELL_CYCLES - 1);
    localparam logic [c_HALF_POS_W-1:0] c_MAX_HALF_POS = c_HALF_POS_W'(2 * (NUM_FLOORS - 1));

    svc_state_e            r_state;
    svc_state_e            w_state_nxt;
    logic [NUM_FLOORS-1:0] r_req;
    logic [NUM_FLOORS-1:0] w_req_nxt;
    logic [NUM_FLOORS-1:0] r_dst;
    logic [NUM_FLOORS-1:0] w_dst_nxt;
    logic                  r_door;
    logic                  w_door_nxt;
    logic                  r_dir;
    logic                  w_dir_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic                  w_serve;

    logic                  w_at_floor;
    logic [NUM_FLOORS-1:0] w_floor_mask;
    logic                  w_hit;

    assign w_at_floor   = half_pos_at_floor(i_half_pos, c_MAX_HALF_POS);
    assign w_floor_mask = w_at_floor ? (NUM_FLOORS'(1) << i_half_pos[c_HALF_POS_W-1:1])
                                     : '0;
    assign w_hit        = |((r_req | r_dst) & w_floor_mask);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_req   <= '0;
            r_dst   <= '0;
            r_door  <= 1'b0;
            r_dir   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_dst   <= w_dst_nxt;
            r_door  <= w_door_nxt;
            r_dir   <= w_dir_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_dst_nxt   = r_dst;
        w_door_nxt  = r_door;
        w_dir_nxt   = r_dir;
        w_cnt_nxt   = r_cnt;
        w_serve     = 1'b0;

        case (i_sim_state)
            START: begin
                w_state_nxt = IDLE;
                w_req_nxt   = '0;
                w_dst_nxt   = '0;
                w_door_nxt  = 1'b0;
                w_dir_nxt   = 1'b0;
                w_cnt_nxt   = '0;
            end
            SIM: begin
                case (r_state)
                    IDLE: begin
                        // Clear is applied after the set so a same-cycle pulse loses.
                        w_req_nxt = r_req | i_hall_pulse;
                        w_dst_nxt = r_dst | i_car_pulse;
                        if (w_hit) begin
                            w_req_nxt   = w_req_nxt & ~w_floor_mask;
                            w_dst_nxt   = w_dst_nxt & ~w_floor_mask;
                            w_state_nxt = DWELL;
                            w_door_nxt  = 1'b1;
                            w_dir_nxt   = i_dir_up;
                            w_cnt_nxt   = c_CNT_LOAD;
                            w_serve     = 1'b1;
                        end
                    end
                    DWELL: begin
                        // Doors are open, so presses for the floor the car sits at are moot.
                        w_req_nxt = r_req | (i_hall_pulse & ~w_floor_mask);
                        w_dst_nxt = r_dst | (i_car_pulse & ~w_floor_mask);
                        if (r_cnt == '0) begin
                            w_state_nxt = IDLE;
                            w_door_nxt  = 1'b0;
                        end else begin
                            w_cnt_nxt = r_cnt - c_CNT_W'(1);
                        end
                    end
                    default: begin
                        w_state_nxt = IDLE;
                    end
                endcase
            end
            default: begin
            end
        endcase
    end

    assign o_floors_requested   = r_req;
    assign o_floor_destinations = r_dst;
    assign o_door_open          = r_door;
    assign o_arrival_dir        = r_dir;
    assign o_serve              = w_serve;

endmodule
`default_nettype wire

// File: rtl/floor_request_tracker.sv
`default_nettype none
// ============================================================================
// Module   : floor_request_tracker
// Purpose  : Latches hall/car calls for two cars, clears them on stops, runs
//            door dwell per car and counts serviced stops.
// Revision : 1.0 - initial release
// ============================================================================
module floor_request_tracker
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = 6,
    parameter int DWELL_CYCLES = 8,
    parameter int CNT_W        = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              simState,
    input  logic [2*NUM_FLOORS-1:0] hall_call_pulse,
    input  logic [2*NUM_FLOORS-1:0] car_call_pulse,
    input  logic [7:0]              half_elevatorPositions,
    input  logic [1:0]              directions,
    output logic [2*NUM_FLOORS-1:0] FloorsRequested,
    output logic [2*NUM_FLOORS-1:0] FloorDestinations,
    output logic [1:0]              door_open,
    output logic [1:0]              arrival_dir,
    output logic [CNT_W-1:0]        served_total
);

    sim_state_e         w_sim_state;
    logic [1:0]         w_serve;
    logic [CNT_W+1:0]   w_sum;
    logic [CNT_W-1:0]   r_served_total;

    assign w_sim_state = sim_state_e'(simState);

    // Index 0 is the left car (low bits), index 1 the right car.
    for (genvar g = 0; g < 2; g++) begin : g_car
        floor_service_unit #(
            .NUM_FLOORS   (NUM_FLOORS),
            .DWELL_CYCLES (DWELL_CYCLES)
        ) u_unit (
            .clk                  (clk),
            .rst                  (rst),
            .i_sim_state          (w_sim_state),
            .i_hall_pulse         (hall_call_pulse[g*NUM_FLOORS +: NUM_FLOORS]),
            .i_car_pulse          (car_call_pulse[g*NUM_FLOORS +: NUM_FLOORS]),
            .i_half_pos           (half_elevatorPositions[g*c_HALF_POS_W +: c_HALF_POS_W]),
            .i_dir_up             (directions[g]),
            .o_floors_requested   (FloorsRequested[g*NUM_FLOORS +: NUM_FLOORS]),
            .o_floor_destinations (FloorDestinations[g*NUM_FLOORS +: NUM_FLOORS]),
            .o_door_open          (door_open[g]),
            .o_arrival_dir        (arrival_dir[g]),
            .o_serve              (w_serve[g])
        );
    end

    assign w_sum = {2'b00, r_served_total}
                 + {{(CNT_W+1){1'b0}}, w_serve[0]}
                 + {{(CNT_W+1){1'b0}}, w_serve[1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_served_total <= '0;
        end else if (w_sim_state == START) begin
            r_served_total <= '0;
        end else if (w_sim_state == SIM) begin
            if (|w_sum[CNT_W+1:CNT_W]) begin
                r_served_total <= '1;
            end else begin
                r_served_total <= w_sum[CNT_W-1:0];
            end
        end
    end

    assign served_total = r_served_total;

endmodule
`default_nettype wire

// File: tb/tb_floor_request_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_floor_request_tracker
// Purpose  : Scenario bench for floor_request_tracker with a queue of
//            expected output snapshots.
// Revision : 1.0 - initial release
// ============================================================================
module tb_floor_request_tracker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  simState;
    logic [11:0] hall_call_pulse;
    logic [11:0] car_call_pulse;
    logic [7:0]  half_elevatorPositions;
    logic [1:0]  directions;
    logic [11:0] FloorsRequested;
    logic [11:0] FloorDestinations;
    logic [1:0]  door_open;
    logic [1:0]  arrival_dir;
    logic [9:0]  served_total;

    typedef struct {
        string       name;
        logic [11:0] fr;
        logic [11:0] fd;
        logic [1:0]  door;
        logic [1:0]  dir;
        logic [9:0]  st;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    exp_t x;
    int   n_tests = 0;
    int   n_fail  = 0;

    floor_request_tracker #(
        .NUM_FLOORS   (6),
        .DWELL_CYCLES (8),
        .CNT_W        (10)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .simState               (simState),
        .hall_call_pulse        (hall_call_pulse),
        .car_call_pulse         (car_call_pulse),
        .half_elevatorPositions (half_elevatorPositions),
        .directions             (directions),
        .FloorsRequested        (FloorsRequested),
        .FloorDestinations      (FloorDestinations),
        .door_open              (door_open),
        .arrival_dir            (arrival_dir),
        .served_total           (served_total)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task test_reset();
        simState = 2'd1;
        hall_call_pulse = '0;
        car_call_pulse = '0;
        half_elevatorPositions = 8'h10;
        directions = 2'b00;
        m = '{"reset_held", 12'h000, 12'h000, 2'b00, 2'b00, 10'd0};
        sb.push_back(m);
        step(2);
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
        rst = 1'b1;
        m.name = "reset_release";
        sb.push_back(m);
        step(1);
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
    endtask

    task test_hall_latch();
        hall_call_pulse = 12'h008;
        m.name = "t1_latch"; m.fr = 12'h008;
        sb.push_back(m);
        step(1);
        hall_call_pulse = '0;
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
        m.name = "t1_hold";
        sb.push_back(m);
        step(2);
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
    endtask

    task test_arrival();
        half_elevatorPositions[3:0] = 4'd6;
        directions[0] = 1'b1;
        m.name = "t2_entry"; m.fr = 12'h000; m.door = 2'b01; m.dir = 2'b01; m.st = 10'd1;
        sb.push_back(m);
        step(1);
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
        m.name = "t2_door_last_cycle";
        sb.push_back(m);
        step(7);
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
        m.name = "t2_door_fall"; m.door = 2'b00;
        sb.push_back(m);
        step(1);
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
        half_elevatorPositions[3:0] = 4'd1;
    endtask

    task test_same_cycle();
        half_elevatorPositions[7:4] = 4'd4;
        directions[1] = 1'b1;
        hall_call_pulse = 12'h100;
        car_call_pulse = 12'h100;
        m.name = "t3_latch_both"; m.fr = 12'h100; m.fd = 12'h100;
        sb.push_back(m);
        step(1);
        hall_call_pulse = '0;
        car_call_pulse = '0;
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
        m.name = "t3_clear_both"; m.fr = 12'h000; m.fd = 12'h000; m.door = 2'b10; m.dir = 2'b11; m.st = 10'd2;
        sb.push_back(m);
        step(1);
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
        m.name = "t3_dwell_end"; m.door = 2'b00;
        sb.push_back(m);
        step(8);
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
        half_elevatorPositions[7:4] = 4'd1;
    endtask

    task test_absorb_pause();
        hall_call_pulse = 12'h008;
        m.name = "t4_prelatch"; m.fr = 12'h008;
        sb.push_back(m);
        step(1);
        hall_call_pulse = '0;
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
        half_elevatorPositions[3:0] = 4'd6;
        directions[0] = 1'b0;
        m.name = "t4_entry"; m.fr = 12'h000; m.door = 2'b01; m.dir = 2'b10; m.st = 10'd3;
        sb.push_back(m);
        step(1);
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
        hall_call_pulse = 12'h028;
        m.name = "t4_absorb"; m.fr = 12'h020;
        sb.push_back(m);
        step(1);
        hall_call_pulse = '0;
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
        simState = 2'd2;
        hall_call_pulse = 12'h001;
        car_call_pulse = 12'h001;
        m.name = "t4_pause_hold";
        sb.push_back(m);
        step(1);
        hall_call_pulse = '0;
        car_call_pulse = '0;
        step(4);
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
        simState = 2'd3;
        m.name = "t4_ending_hold";
        sb.push_back(m);
        step(2);
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
        simState = 2'd1;
        m.name = "t4_resume_high";
        sb.push_back(m);
        step(6);
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
        m.name = "t4_door_fall"; m.door = 2'b00;
        sb.push_back(m);
        step(1);
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
    endtask

    task test_position_decode();
        hall_call_pulse = 12'h004;
        m.name = "t5_latch_f2"; m.fr = 12'h024;
        sb.push_back(m);
        step(1);
        hall_call_pulse = '0;
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin half_elevatorPositions[3:0] = 4'd5;  m.name = "t5_odd_p5"; end
                1:       begin half_elevatorPositions[3:0] = 4'd11; m.name = "t5_range_p11"; end
                default: begin half_elevatorPositions[3:0] = 4'd12; m.name = "t5_range_p12"; end
            endcase
            sb.push_back(m);
            step(3);
            x = sb.pop_front(); n_tests++;
            if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
                n_fail++;
                $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
            end
        end
        half_elevatorPositions[3:0] = 4'd10;
        directions[0] = 1'b1;
        m.name = "t5_top_floor"; m.fr = 12'h004; m.door = 2'b01; m.dir = 2'b11; m.st = 10'd4;
        sb.push_back(m);
        step(1);
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
        m.name = "t5_top_end"; m.door = 2'b00;
        sb.push_back(m);
        step(8);
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
    endtask

    task test_saturate_start_reset();
        half_elevatorPositions = 8'h00;
        directions = 2'b10;
        // Both cars stop at floor 0 every ten cycles, two stops per round.
        while (m.st < 10'd1022) begin
            hall_call_pulse = 12'h041;
            step(1);
            hall_call_pulse = '0;
            step(9);
            m.st = m.st + 10'd2;
        end
        m.name = "t6_preload"; m.dir = 2'b10;
        sb.push_back(m);
        step(1);
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
        for (int r = 0; r < 2; r++) begin
            hall_call_pulse = 12'h041;
            step(1);
            hall_call_pulse = '0;
            m.name = (r == 0) ? "t6_sat_from_1022" : "t6_sat_hold"; m.door = 2'b11; m.st = 10'd1023;
            sb.push_back(m);
            step(1);
            x = sb.pop_front(); n_tests++;
            if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
                n_fail++;
                $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
            end
            if (r == 0) begin
                step(8);
            end
        end
        simState = 2'd0;
        m = '{"t6_start_clear", 12'h000, 12'h000, 2'b00, 2'b00, 10'd0};
        sb.push_back(m);
        step(1);
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
        simState = 2'd1;
        directions = 2'b01;
        hall_call_pulse = 12'h001;
        step(1);
        hall_call_pulse = '0;
        m = '{"t6_redwell", 12'h000, 12'h000, 2'b01, 2'b01, 10'd1};
        sb.push_back(m);
        step(1);
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
        step(2);
        rst = 1'b0;
        m = '{"t6_async_rst", 12'h000, 12'h000, 2'b00, 2'b00, 10'd0};
        sb.push_back(m);
        #2;
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
        rst = 1'b1;
        m.name = "t6_after_rst";
        sb.push_back(m);
        step(2);
        x = sb.pop_front(); n_tests++;
        if ({FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total} !== {x.fr, x.fd, x.door, x.dir, x.st}) begin
            n_fail++;
            $display("FAIL %s: got fr=%h fd=%h door=%b dir=%b st=%0d, expected fr=%h fd=%h door=%b dir=%b st=%0d", x.name, FloorsRequested, FloorDestinations, door_open, arrival_dir, served_total, x.fr, x.fd, x.door, x.dir, x.st);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish, required finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_hall_latch();
        test_arrival();
        test_same_cycle();
        test_absorb_pause();
        test_position_decode();
        test_saturate_start_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
